// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared state encoding and stream constants for the boot loader
package imem_boot_loader_pkg;
  typedef enum logic [2:0] {HDR0, HDR1, LOAD, CSUM, DONE, ERR} state_t;
  localparam int LANES = 4;
  localparam int HDR_BYTES = 2;
  localparam logic [7:0] CSUM_INIT = 8'h00;
endpackage

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: decodes a length-prefixed byte stream into byte-lane imem writes with checksum gating of cpu_rst
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int MAX_WORDS = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        start,
  output logic [3:0]  imem_we,
  output logic [31:0] imem_wr_addr,
  output logic [7:0]  imem_wr_data,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [9:0]  words_loaded
);
  localparam int BW = $clog2(MAX_WORDS * LANES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);
  localparam logic [9:0] MAX_WL = 10'(MAX_WORDS);
  state_t state, state_nx;
  logic [7:0] len_lo, sum;
  logic [15:0] hdr_len;
  logic [BW-1:0] cnt, last_q;
  logic acc, pay, rearm;
  assign hdr_len = {rx_data, len_lo};
  assign rx_ready = !rst && state != DONE && state != ERR;
  assign acc = rx_valid && rx_ready;
  assign pay = acc && state == LOAD;
  assign rearm = start && (state == DONE || state == ERR);
  always_comb begin
    state_nx = state;
    case (state)
      HDR0: state_nx = acc ? HDR1 : HDR0;
      HDR1: state_nx = !acc ? HDR1 : hdr_len > MAX_LEN ? ERR : hdr_len == 16'd0 ? CSUM : LOAD;
      LOAD: state_nx = (pay && cnt == last_q) ? CSUM : LOAD;
      CSUM: state_nx = !acc ? CSUM : rx_data == sum ? DONE : ERR;
      DONE: state_nx = start ? HDR0 : DONE;
      ERR:  state_nx = start ? HDR0 : ERR;
      default: state_nx = HDR0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR0;
      len_lo <= 8'd0;
      last_q <= '0;
      cnt <= '0;
      sum <= CSUM_INIT;
      imem_we <= 4'b0000;
      imem_wr_addr <= BASE_ADDR;
      imem_wr_data <= 8'd0;
      cpu_rst <= 1'b1;
      load_done <= 1'b0;
      load_err <= 1'b0;
      words_loaded <= 10'd0;
    end else begin
      state <= state_nx;
      imem_we <= pay ? 4'b0001 << cnt[1:0] : 4'b0000;
      cpu_rst <= state_nx != DONE;
      load_done <= state_nx == DONE;
      load_err <= state_nx == ERR;
      if (acc && state == HDR0) len_lo <= rx_data;
      // index of the final payload byte, 4N-1; only meaningful once N passed the length check
      if (acc && state == HDR1) last_q <= BW'({hdr_len, 2'b00} - 18'd1);
      if (pay) begin
        cnt <= cnt + 1'b1;
        sum <= sum + rx_data;
        imem_wr_data <= rx_data;
        imem_wr_addr <= BASE_ADDR + 32'({cnt[BW-1:2], 2'b00});
        if (cnt[1:0] == 2'd3 && words_loaded != MAX_WL) words_loaded <= words_loaded + 10'd1;
      end
      if (rearm) begin
        cnt <= '0;
        sum <= CSUM_INIT;
        words_loaded <= 10'd0;
      end
    end
  end
endmodule
